// File: rtl/adc_fifo_reader_pkg.sv
// Shared types and constants for the ADC capture FIFO read-side controller.
package adc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_CAP,
    S_DATA,
    S_SUM,
    S_CLR,
    S_WAITLOW
  } rd_state_t;

  localparam logic [7:0]  SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0]  SYNC1_DEFAULT = 8'h5A;
  localparam int unsigned HDR_BYTES     = 4;

endpackage

// File: rtl/adc_fifo_reader_byte_tx_reg.sv
// Output holding register for the TX byte stream: loads on request, drops valid
// once the sink accepts. A load in the same cycle as acceptance wins.
module byte_tx_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] load_data_i,
  input  logic       tx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o
);

  logic [7:0] data_q;
  logic       valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= load_data_i;
      valid_q <= 1'b1;
    end else if (valid_q && tx_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign tx_data_o  = data_q;
  assign tx_valid_o = valid_q;

endmodule

// File: rtl/adc_fifo_reader.sv
// Drains a full ADC capture buffer and frames it as header + payload + checksum
// on the SPI TX byte interface, then pulses clear to re-arm the capture side.
module adc_fifo_reader
  import adc_pkg::*;
#(
  parameter int unsigned MAX_LEN = 3000,
  parameter logic [7:0]  SYNC0   = SYNC0_DEFAULT,
  parameter logic [7:0]  SYNC1   = SYNC1_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_en,
  input  logic [31:0] len,
  input  logic [7:0]  fifo_q,
  output logic        fifo_rdreq,
  output logic        clear,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy
);

  rd_state_t   state_q, state_d;
  logic [15:0] plen_q, plen_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [1:0]  hidx_q, hidx_d;
  logic        rdreq_q, rdreq_d;
  logic        clear_q, clear_d;
  logic        busy_q, busy_d;
  logic        first_q;

  logic        ld;
  logic [7:0]  ld_data;
  logic [15:0] plen_calc;
  logic [1:0]  hidx_nxt;
  logic        accept;

  assign plen_calc = (len > 32'(MAX_LEN)) ? 16'(MAX_LEN) : len[15:0];
  assign accept    = tx_valid & tx_ready;
  assign hidx_nxt  = hidx_q + 2'd1;

  // Registered strobes are set on the transition into their state so each
  // output is high exactly while the FSM sits in RD / CLR.
  always_comb begin
    state_d = state_q;
    plen_d  = plen_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    hidx_d  = hidx_q;
    rdreq_d = 1'b0;
    clear_d = 1'b0;
    ld      = 1'b0;
    ld_data = '0;
    case (state_q)
      S_IDLE: begin
        if (send_en) begin
          if (first_q) begin
            state_d = S_CLR;
            clear_d = 1'b1;
          end else begin
            state_d = S_HDR;
            plen_d  = plen_calc;
            cnt_d   = '0;
            csum_d  = '0;
            hidx_d  = '0;
            ld      = 1'b1;
            ld_data = SYNC0;
          end
        end
      end
      S_HDR: begin
        if (accept) begin
          if (hidx_q == 2'(HDR_BYTES - 1)) begin
            if (plen_q != '0) begin
              state_d = S_RD;
              rdreq_d = 1'b1;
            end else begin
              state_d = S_SUM;
              ld      = 1'b1;
              ld_data = csum_q;
            end
          end else begin
            hidx_d = hidx_nxt;
            ld     = 1'b1;
            case (hidx_nxt)
              2'd1:    ld_data = SYNC1;
              2'd2:    ld_data = plen_q[15:8];
              2'd3:    ld_data = plen_q[7:0];
              default: ld_data = SYNC0;
            endcase
          end
        end
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        state_d = S_DATA;
        ld      = 1'b1;
        ld_data = fifo_q;
        csum_d  = csum_q + fifo_q;
        cnt_d   = cnt_q + 16'd1;
      end
      S_DATA: begin
        if (accept) begin
          if (cnt_q < plen_q) begin
            state_d = S_RD;
            rdreq_d = 1'b1;
          end else begin
            state_d = S_SUM;
            ld      = 1'b1;
            ld_data = csum_q;
          end
        end
      end
      S_SUM: begin
        if (accept) begin
          state_d = S_CLR;
          clear_d = 1'b1;
        end
      end
      S_CLR: state_d = S_WAITLOW;
      S_WAITLOW: begin
        if (!send_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      plen_q  <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      hidx_q  <= '0;
      rdreq_q <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      plen_q  <= plen_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      hidx_q  <= hidx_d;
      rdreq_q <= rdreq_d;
      clear_q <= clear_d;
      busy_q  <= busy_d;
      first_q <= 1'b0;
    end
  end

  byte_tx_reg u_tx (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ld),
    .load_data_i (ld_data),
    .tx_ready_i  (tx_ready),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid)
  );

  assign fifo_rdreq = rdreq_q;
  assign clear      = clear_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_adc_fifo_reader.sv
// Directed bench for adc_fifo_reader: FIFO model, TX monitor, one task per scenario.
module tb_adc_fifo_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        send_en;
  logic [31:0] len;
  logic [7:0]  fifo_q;
  logic        fifo_rdreq;
  logic        clear;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  logic ready_level;
  logic rand_mode;
  logic rand_bit = 1'b1;
  assign tx_ready = rand_mode ? rand_bit : ready_level;

  adc_fifo_reader #(.MAX_LEN(3000), .SYNC0(8'hA5), .SYNC1(8'h5A)) dut (
    .clk        (clk),
    .rst        (rst),
    .send_en    (send_en),
    .len        (len),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .clear      (clear),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rand_bit = ($urandom_range(0, 99) < 30);
  end

  // FIFO read port: data valid one cycle after the read strobe
  logic [7:0] mem [0:4999];
  int rd_base = 0;
  int rd_total = 0;
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      fifo_q   <= mem[(rd_total - rd_base) % 5000];
      rd_total <= rd_total + 1;
    end
  end

  logic [7:0] txq [$];
  int valid_cycles = 0, clear_cnt = 0, rdreq_cnt = 0;
  int dbl_rd = 0, rd_in_valid = 0, stall_viol = 0;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_rd = 1'b0;
  logic [7:0] prev_d = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (tx_valid) valid_cycles <= valid_cycles + 1;
      if (clear) clear_cnt <= clear_cnt + 1;
      if (fifo_rdreq) begin
        rdreq_cnt <= rdreq_cnt + 1;
        if (prev_rd) dbl_rd <= dbl_rd + 1;
        if (tx_valid) rd_in_valid <= rd_in_valid + 1;
      end
      if (prev_v && !prev_r && (tx_valid !== 1'b1 || tx_data !== prev_d))
        stall_viol <= stall_viol + 1;
    end
    prev_v  <= tx_valid && !rst;
    prev_r  <= tx_ready;
    prev_d  <= tx_data;
    prev_rd <= fifo_rdreq && !rst;
  end

  int total = 0;
  int bad = 0;

  task automatic settle;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [31:0] l);
    settle();
    len     = l;
    send_en = 1'b1;
    @(posedge clk);
  endtask

  task automatic wait_clear(input int budget, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (clear === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic end_frame;
    settle();
    send_en = 1'b0;
    repeat (3) @(negedge clk);
    settle();
  endtask

  task automatic test_reset;
    rst = 1'b1; send_en = 1'b0; len = '0; ready_level = 1'b1; rand_mode = 1'b0;
    #3;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    total++; if (fifo_rdreq !== 1'b0) begin bad++; $display("FAIL reset_rdreq got=%b exp=0", fifo_rdreq); end
    total++; if (clear !== 1'b0) begin bad++; $display("FAIL reset_clear got=%b exp=0", clear); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    settle();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || clear !== 1'b0) begin bad++; $display("FAIL idle_after_reset busy=%b clear=%b exp=0,0", busy, clear); end
    settle();
  endtask

  task automatic test_basic;
    logic [7:0] exp [8];
    int s, c0, r0, cyc;
    bit seen;
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h03, 8'h0A, 8'h14, 8'h1E, 8'h3C};
    mem[0] = 8'h0A; mem[1] = 8'h14; mem[2] = 8'h1E;
    rd_base = rd_total; s = txq.size(); c0 = clear_cnt; r0 = rdreq_cnt;
    start_frame(32'd3);
    @(negedge clk);
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin bad++; $display("FAIL basic_first_byte valid=%b data=%h exp=1,a5", tx_valid, tx_data); end
    wait_clear(200, cyc, seen);
    total++; if (!seen) begin bad++; $display("FAIL basic_clear_timeout got=none exp=clear"); end
    total++; if (cyc + 1 !== 15) begin bad++; $display("FAIL basic_frame_cycles got=%0d exp=15", cyc + 1); end
    @(negedge clk);
    total++; if (clear !== 1'b0) begin bad++; $display("FAIL basic_clear_width got=%b exp=0", clear); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_waitlow got=%b exp=1", busy); end
    settle();
    send_en = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
    settle();
    total++; if (txq.size() - s !== 8) begin bad++; $display("FAIL basic_tx_count got=%0d exp=8", txq.size() - s); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] got;
      got = (s + i < txq.size()) ? txq[s + i] : 8'hxx;
      total++; if (got !== exp[i]) begin bad++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    total++; if (rdreq_cnt - r0 !== 3) begin bad++; $display("FAIL basic_reads got=%0d exp=3", rdreq_cnt - r0); end
    total++; if (clear_cnt - c0 !== 1) begin bad++; $display("FAIL basic_clears got=%0d exp=1", clear_cnt - c0); end
  endtask

  task automatic test_maxlen;
    int s, r0, d0, cyc, mism;
    bit seen;
    logic [7:0] csum, got;
    csum = '0;
    for (int i = 0; i < 5000; i++) begin
      mem[i] = 8'(i * 37 + 11);
      if (i < 3000) csum = csum + mem[i];
    end
    rd_base = rd_total; s = txq.size(); r0 = rdreq_cnt; d0 = dbl_rd;
    start_frame(32'd5000);
    wait_clear(12000, cyc, seen);
    total++; if (!seen) begin bad++; $display("FAIL max_clear_timeout got=none exp=clear"); end
    end_frame();
    total++; if (txq.size() - s !== 3005) begin bad++; $display("FAIL max_tx_count got=%0d exp=3005", txq.size() - s); end
    if (txq.size() - s >= 3005) begin
      total++; if (txq[s + 2] !== 8'h0B || txq[s + 3] !== 8'hB8) begin bad++; $display("FAIL max_hdr_len got=%h%h exp=0bb8", txq[s + 2], txq[s + 3]); end
      mism = 0;
      for (int i = 0; i < 3000; i++) if (txq[s + 4 + i] !== mem[i]) mism++;
      total++; if (mism !== 0) begin bad++; $display("FAIL max_payload got=%0d_mismatches exp=0", mism); end
      got = txq[s + 3004];
      total++; if (got !== csum) begin bad++; $display("FAIL max_csum got=%h exp=%h", got, csum); end
    end
    total++; if (rdreq_cnt - r0 !== 3000) begin bad++; $display("FAIL max_reads got=%0d exp=3000", rdreq_cnt - r0); end
    total++; if (dbl_rd - d0 !== 0) begin bad++; $display("FAIL max_back_to_back_reads got=%0d exp=0", dbl_rd - d0); end
  endtask

  task automatic test_zero_len;
    logic [7:0] exp [5];
    int s, c0, r0, cyc;
    bit seen;
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
    rd_base = rd_total; s = txq.size(); c0 = clear_cnt; r0 = rdreq_cnt;
    start_frame(32'd0);
    @(negedge clk);
    wait_clear(100, cyc, seen);
    total++; if (!seen || cyc + 1 !== 6) begin bad++; $display("FAIL zero_frame_cycles got=%0d exp=6", cyc + 1); end
    end_frame();
    total++; if (txq.size() - s !== 5) begin bad++; $display("FAIL zero_tx_count got=%0d exp=5", txq.size() - s); end
    for (int i = 0; i < 5; i++) begin
      logic [7:0] got;
      got = (s + i < txq.size()) ? txq[s + i] : 8'hxx;
      total++; if (got !== exp[i]) begin bad++; $display("FAIL zero_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
    total++; if (rdreq_cnt - r0 !== 0) begin bad++; $display("FAIL zero_reads got=%0d exp=0", rdreq_cnt - r0); end
    total++; if (clear_cnt - c0 !== 1) begin bad++; $display("FAIL zero_clears got=%0d exp=1", clear_cnt - c0); end
  endtask

  task automatic test_stall;
    logic [7:0] exp [8];
    int s, r0, sv0, rv0, cyc;
    bit seen;
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h03, 8'h0A, 8'h14, 8'h1E, 8'h3C};
    mem[0] = 8'h0A; mem[1] = 8'h14; mem[2] = 8'h1E;
    rd_base = rd_total; s = txq.size(); r0 = rdreq_cnt; sv0 = stall_viol; rv0 = rd_in_valid;
    rand_mode = 1'b1;
    start_frame(32'd3);
    wait_clear(2000, cyc, seen);
    total++; if (!seen) begin bad++; $display("FAIL stall_clear_timeout got=none exp=clear"); end
    settle();
    rand_mode = 1'b0;
    end_frame();
    total++; if (stall_viol - sv0 !== 0) begin bad++; $display("FAIL stall_data_stable got=%0d_changes exp=0", stall_viol - sv0); end
    total++; if (rd_in_valid - rv0 !== 0) begin bad++; $display("FAIL stall_read_while_valid got=%0d exp=0", rd_in_valid - rv0); end
    total++; if (rdreq_cnt - r0 !== 3) begin bad++; $display("FAIL stall_reads got=%0d exp=3", rdreq_cnt - r0); end
    total++; if (txq.size() - s !== 8) begin bad++; $display("FAIL stall_tx_count got=%0d exp=8", txq.size() - s); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] got;
      got = (s + i < txq.size()) ? txq[s + i] : 8'hxx;
      total++; if (got !== exp[i]) begin bad++; $display("FAIL stall_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] exp [8];
    int s, cyc;
    bit seen;
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'h02, 8'h00};
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h02;
    rd_base = rd_total; s = txq.size();
    start_frame(32'd3);
    wait_clear(200, cyc, seen);
    total++; if (!seen) begin bad++; $display("FAIL wrap_clear_timeout got=none exp=clear"); end
    end_frame();
    total++; if (txq.size() - s !== 8) begin bad++; $display("FAIL wrap_tx_count got=%0d exp=8", txq.size() - s); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] got;
      got = (s + i < txq.size()) ? txq[s + i] : 8'hxx;
      total++; if (got !== exp[i]) begin bad++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp [5];
    int s, c0, r0, v0, cyc;
    bit found, seen;
    exp = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
    mem[0] = 8'h0A; mem[1] = 8'h14; mem[2] = 8'h1E;
    rd_base = rd_total;
    start_frame(32'd3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      settle();
      if (fifo_rdreq === 1'b1) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL rstmid_no_read got=none exp=rdreq"); end
    ready_level = 1'b0;
    settle(); settle();
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h0A) begin bad++; $display("FAIL rstmid_in_data valid=%b data=%h exp=1,0a", tx_valid, tx_data); end
    #1 rst = 1'b1;
    #1;
    total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin bad++; $display("FAIL rstmid_async_tx valid=%b data=%h exp=0,00", tx_valid, tx_data); end
    total++; if (busy !== 1'b0 || clear !== 1'b0 || fifo_rdreq !== 1'b0) begin bad++; $display("FAIL rstmid_async_ctrl busy=%b clear=%b rdreq=%b exp=0,0,0", busy, clear, fifo_rdreq); end
    settle(); settle();
    c0 = clear_cnt; r0 = rdreq_cnt; v0 = valid_cycles;
    rst = 1'b0;
    ready_level = 1'b1;
    repeat (10) @(negedge clk);
    settle();
    total++; if (clear_cnt - c0 !== 1) begin bad++; $display("FAIL rstmid_discard_clear got=%0d exp=1", clear_cnt - c0); end
    total++; if (valid_cycles - v0 !== 0) begin bad++; $display("FAIL rstmid_no_tx got=%0d exp=0", valid_cycles - v0); end
    total++; if (rdreq_cnt - r0 !== 0) begin bad++; $display("FAIL rstmid_no_reads got=%0d exp=0", rdreq_cnt - r0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_held_waitlow got=%b exp=1", busy); end
    send_en = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_rearm_idle got=%b exp=0", busy); end
    settle();
    s = txq.size(); rd_base = rd_total;
    start_frame(32'd0);
    wait_clear(100, cyc, seen);
    total++; if (!seen) begin bad++; $display("FAIL rstmid_rearm_timeout got=none exp=clear"); end
    end_frame();
    total++; if (txq.size() - s !== 5) begin bad++; $display("FAIL rstmid_rearm_count got=%0d exp=5", txq.size() - s); end
    for (int i = 0; i < 5; i++) begin
      logic [7:0] got;
      got = (s + i < txq.size()) ? txq[s + i] : 8'hxx;
      total++; if (got !== exp[i]) begin bad++; $display("FAIL rstmid_rearm_byte%0d got=%h exp=%h", i, got, exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_maxlen();
    test_zero_len();
    test_stall();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
